// File: rtl/pipe_pkg.sv
// Shared types for the MEM stage: handshake FSM states and the EX/MEM, MEM/WB payloads.
package pipe_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        HS_IDLE = 1'b0,
        HS_WAIT = 1'b1
    } hs_state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       store_data;
    } ex_mem_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic [XLEN-1:0]       wdata;
    } mem_wb_t;

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory request/ready handshake: request generation, pipeline stall and wait tracking.
module dmem_handshake
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic memread_i,
    input  logic memwrite_i,
    input  logic dmem_ready_i,
    output logic dmem_req_c_o,
    output logic dmem_we_c_o,
    output logic stall_c_o
);

    hs_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        dmem_req_c_o = 1'b0;
        dmem_we_c_o  = 1'b0;
        stall_c_o    = 1'b0;
        state_d      = state_q;

        dmem_req_c_o = valid_i & (memread_i | memwrite_i);
        dmem_we_c_o  = valid_i & memwrite_i;
        stall_c_o    = dmem_req_c_o & ~dmem_ready_i;

        unique case (state_q)
            HS_IDLE: if (dmem_req_c_o && !dmem_ready_i) state_d = HS_WAIT;
            HS_WAIT: if (dmem_ready_i)                  state_d = HS_IDLE;
            default:                                    state_d = HS_IDLE;
        endcase
    end

    // EX/MEM is frozen while waiting, so the request can never drop out of WAIT.
    a_wait_holds_req: assert property (@(posedge clk) disable iff (rst)
        (state_q == HS_WAIT) |-> dmem_req_c_o);

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM stage: EX/MEM and MEM/WB pipeline registers around a stalling data-memory handshake.
module mem_stage_pipe #(
    parameter int unsigned XLEN = pipe_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic            ex_memwrite,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [4:0]      ex_mem_rd,
    output logic            ex_mem_regwrite,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [4:0]      mem_wb_rd,
    output logic            mem_wb_regwrite,
    output logic [XLEN-1:0] mem_wb_wdata,
    output logic            stall,
    output logic [31:0]     stall_count
);

    pipe_pkg::ex_mem_t ex_mem_q, ex_mem_d;
    pipe_pkg::mem_wb_t mem_wb_q, mem_wb_d;
    logic [31:0]       stall_count_q, stall_count_d;
    logic              dmem_req_c, dmem_we_c, stall_c;

    dmem_handshake u_handshake (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (ex_mem_q.valid),
        .memread_i    (ex_mem_q.memread),
        .memwrite_i   (ex_mem_q.memwrite),
        .dmem_ready_i (dmem_ready),
        .dmem_req_c_o (dmem_req_c),
        .dmem_we_c_o  (dmem_we_c),
        .stall_c_o    (stall_c)
    );

    // Stores never write the register file, so regwrite is dropped at capture.
    always_comb begin
        ex_mem_d = ex_mem_q;
        if (!stall_c) begin
            ex_mem_d = '0;
            if (ex_valid) begin
                ex_mem_d.valid      = 1'b1;
                ex_mem_d.rd         = ex_rd;
                ex_mem_d.regwrite   = ex_regwrite & ~ex_memwrite;
                ex_mem_d.memread    = ex_memread;
                ex_mem_d.memwrite   = ex_memwrite;
                ex_mem_d.alu_result = ex_alu_result;
                ex_mem_d.store_data = ex_store_data;
            end
        end
    end

    always_comb begin
        mem_wb_d = '0;
        if (!stall_c) begin
            mem_wb_d.valid    = ex_mem_q.valid;
            mem_wb_d.rd       = ex_mem_q.rd;
            mem_wb_d.regwrite = ex_mem_q.regwrite;
            mem_wb_d.wdata    = ex_mem_q.memread ? dmem_rdata : ex_mem_q.alu_result;
        end
        stall_count_d = stall_count_q + 32'(stall_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_q      <= '0;
            mem_wb_q      <= '0;
            stall_count_q <= '0;
        end else begin
            ex_mem_q      <= ex_mem_d;
            mem_wb_q      <= mem_wb_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign dmem_req          = dmem_req_c;
    assign dmem_we           = dmem_we_c;
    assign dmem_addr         = ex_mem_q.alu_result;
    assign dmem_wdata        = ex_mem_q.store_data;
    assign stall             = stall_c;
    assign stall_count       = stall_count_q;
    assign ex_mem_rd         = ex_mem_q.rd;
    assign ex_mem_regwrite   = ex_mem_q.valid & ex_mem_q.regwrite;
    assign ex_mem_alu_result = ex_mem_q.alu_result;
    assign mem_wb_rd         = mem_wb_q.rd;
    assign mem_wb_regwrite   = mem_wb_q.valid & mem_wb_q.regwrite;
    assign mem_wb_wdata      = mem_wb_q.wdata;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe: directed scenarios then randomized instruction stream.
`timescale 1ns/1ps
module tb_mem_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_result, ex_store_data;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic        ex_mem_regwrite, mem_wb_regwrite, stall;
    logic [31:0] ex_mem_alu_result, mem_wb_wdata, stall_count;

    always #5 clk = ~clk;

    mem_stage_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_alu_result(ex_mem_alu_result),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_wdata(mem_wb_wdata),
        .stall(stall), .stall_count(stall_count)
    );

    typedef struct { logic [4:0] rd; logic [31:0] wdata; } retire_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mreq_t;

    retire_t     retq[$];
    mreq_t       reqq[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] resp_mem  [logic [31:0]];

    int errors = 0;
    int checks = 0;
    int fixed_wait = -1;
    int exp_sc = 0;
    int stall_win = 0;
    bit resp_stall = 1'b0;
    bit prev_stall = 1'b0;
    bit mon_en = 1'b0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] resp_rd(input logic [31:0] a);
        return resp_mem.exists(a) ? resp_mem[a] : mem_init(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Present one EX-stage instruction, hold it while upstream is stalled, record expectations.
    task automatic issue(input bit v, input logic [4:0] rd, input bit rw, input bit mr,
                         input bit mw, input logic [31:0] alu, input logic [31:0] sd);
        int guard = 0;
        ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
        ex_alu_result = alu; ex_store_data = sd;
        forever begin
            @(negedge clk);
            if (!stall) break;
            guard++;
            if (guard > 64) begin
                fail_now("issue_timeout");
                break;
            end
        end
        if (v) begin
            if (mr || mw) reqq.push_back('{alu, mw, sd});
            if (rw && !mw) retq.push_back('{rd, mr ? model_rd(alu) : alu});
            if (mw) model_mem[alu] = sd;
        end
        @(posedge clk); #2;
    endtask

    task automatic bubble();
        issue(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        retq.delete();
        reqq.delete();
    endtask

    // Data-memory responder: checks each request, inserts wait states, returns load data.
    initial begin : responder
        bit          pend;
        int          waits;
        mreq_t       r;
        logic [31:0] h_addr, h_wdata;
        logic        h_we;
        pend = 1'b0; waits = 0;
        dmem_ready = 1'b0; dmem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            resp_stall = 1'b0;
            if (dmem_req === 1'b1) begin
                if (!pend) begin
                    if (reqq.size() == 0) begin
                        fail_now("unexpected_dmem_req");
                    end else begin
                        r = reqq.pop_front();
                        check("req_addr", dmem_addr, r.addr);
                        check("req_we", 32'(dmem_we), 32'(r.we));
                        if (r.we) check("req_wdata", dmem_wdata, r.wdata);
                    end
                    h_addr = dmem_addr; h_we = dmem_we; h_wdata = dmem_wdata;
                    if (fixed_wait >= 0) waits = fixed_wait;
                    else waits = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
                    pend = 1'b1;
                end else begin
                    check("hold_addr", dmem_addr, h_addr);
                    check("hold_we", 32'(dmem_we), 32'(h_we));
                    check("hold_wdata", dmem_wdata, h_wdata);
                end
                if (waits == 0) begin
                    dmem_ready = 1'b1;
                    pend = 1'b0;
                    if (dmem_we) resp_mem[dmem_addr] = dmem_wdata;
                    else dmem_rdata = resp_rd(dmem_addr);
                end else begin
                    dmem_ready = 1'b0;
                    dmem_rdata = $urandom;
                    waits--;
                    resp_stall = 1'b1;
                end
            end else begin
                pend = 1'b0;
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: retirement scoreboard, stall and stall_count tracking.
    always @(negedge clk) begin
        retire_t e;
        if (mon_en) begin
            check("stall", 32'(stall), 32'(resp_stall));
            check("stall_count", stall_count, 32'(exp_sc));
            if (prev_stall) check("bubble_after_stall", 32'(mem_wb_regwrite), 32'd0);
            if (mem_wb_regwrite === 1'b1) begin
                if (retq.size() == 0) begin
                    fail_now("unexpected_retire");
                end else begin
                    e = retq.pop_front();
                    check("retire_rd", 32'(mem_wb_rd), 32'(e.rd));
                    check("retire_wdata", mem_wb_wdata, e.wdata);
                end
            end
        end
        if (stall === 1'b1) stall_win++;
        prev_stall = (stall === 1'b1) && !rst;
        exp_sc = rst ? 0 : exp_sc + int'(resp_stall);
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a;
        int          kind;
        rst = 1'b1;
        ex_valid = 1'b0; ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
        ex_alu_result = 32'd0; ex_store_data = 32'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        check("reset_dmem_req", 32'(dmem_req), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_ex_mem_regwrite", 32'(ex_mem_regwrite), 32'd0);
        check("reset_mem_wb_regwrite", 32'(mem_wb_regwrite), 32'd0);
        check("reset_stall_count", stall_count, 32'd0);
        mon_en = 1'b1;

        // ALU op flows through both registers without stalling
        fixed_wait = 0; stall_win = 0;
        issue(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
        check("alu_ex_mem_rd", 32'(ex_mem_rd), 32'd5);
        check("alu_ex_mem_regwrite", 32'(ex_mem_regwrite), 32'd1);
        bubble();
        check("alu_mem_wb_wdata", mem_wb_wdata, 32'h10);
        check("alu_mem_wb_regwrite", 32'(mem_wb_regwrite), 32'd1);
        check("alu_no_stall", 32'(stall_win), 32'd0);

        // Zero-wait load
        a = 32'h40;
        model_mem[a] = 32'hDEADBEEF; resp_mem[a] = 32'hDEADBEEF;
        stall_win = 0;
        issue(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, a, 32'd0);
        bubble();
        check("load0_mem_wb_wdata", mem_wb_wdata, 32'hDEADBEEF);
        check("load0_mem_wb_rd", 32'(mem_wb_rd), 32'd3);
        check("load0_no_stall", 32'(stall_win), 32'd0);

        // Load with three wait states
        do_reset();
        fixed_wait = 3; stall_win = 0;
        issue(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 32'h100, 32'd0);
        check("load3_addr", dmem_addr, 32'h100);
        bubble();
        check("load3_stall_cycles", 32'(stall_win), 32'd3);
        check("load3_stall_count", stall_count, 32'd3);
        check("load3_wdata", mem_wb_wdata, mem_init(32'h100));

        // Store ignores ex_regwrite
        fixed_wait = 0;
        issue(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 32'h20, 32'h55);
        check("store_req", 32'(dmem_req), 32'd1);
        check("store_we", 32'(dmem_we), 32'd1);
        check("store_addr", dmem_addr, 32'h20);
        check("store_wdata", dmem_wdata, 32'h55);
        check("store_ex_mem_regwrite", 32'(ex_mem_regwrite), 32'd0);
        bubble();
        check("store_mem_wb_regwrite", 32'(mem_wb_regwrite), 32'd0);

        // Invalid EX slot with regwrite set stays a bubble
        issue(1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h77, 32'd0);
        check("bubble_ex_mem_regwrite", 32'(ex_mem_regwrite), 32'd0);
        bubble();
        check("bubble_mem_wb_regwrite", 32'(mem_wb_regwrite), 32'd0);

        // Reset in the second wait cycle while ready arrives
        fixed_wait = 2;
        reqq.push_back('{32'h140, 1'b0, 32'd0});
        ex_valid = 1'b1; ex_rd = 5'd6; ex_regwrite = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0;
        ex_alu_result = 32'h140; ex_store_data = 32'd0;
        @(posedge clk); #2;
        ex_valid = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        check("rstwait_dmem_req", 32'(dmem_req), 32'd0);
        check("rstwait_stall", 32'(stall), 32'd0);
        check("rstwait_ex_mem_regwrite", 32'(ex_mem_regwrite), 32'd0);
        check("rstwait_mem_wb_regwrite", 32'(mem_wb_regwrite), 32'd0);
        check("rstwait_stall_count", stall_count, 32'd0);
        rst = 1'b0;
        retq.delete();
        reqq.delete();

        // Randomized instruction stream against the memory/register model
        fixed_wait = -1;
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 19));
            a = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
            if (kind < 8)
                issue(1'b1, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), 1'b0, 1'b0,
                      $urandom, $urandom);
            else if (kind < 13)
                issue(1'b1, 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), 1'b1, 1'b0,
                      a, $urandom);
            else if (kind < 17)
                issue(1'b1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
                      a, $urandom);
            else
                issue(1'b0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0, a, $urandom);
        end
        repeat (4) bubble();
        check("final_retire_queue_empty", 32'(retq.size()), 32'd0);
        check("final_req_queue_empty", 32'(reqq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
